// File: rtl/ieeedrv_sd_resp.sv
// Track-transfer responder for the IEEE subdrives: arbitrates sd_rd/sd_wr requests and
// moves whole tracks of 256-byte sectors between the byte-wide image memory and the track buffer.
module ieeedrv_sd_resp #(
  parameter int SUBDRV = 2,
  parameter int AW     = 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba      [SUBDRV],
  input  logic [5:0]        sd_blk_cnt  [SUBDRV],
  input  logic [SUBDRV-1:0] sd_rd,
  input  logic [SUBDRV-1:0] sd_wr,
  output logic [SUBDRV-1:0] sd_ack,
  output logic [13:0]       sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din [SUBDRV],
  output logic [AW-1:0]     mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ready
);
  localparam int NS = SUBDRV - 1;
  localparam int DW = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t            state;
  logic [DW-1:0]     drv;
  logic [DW-1:0]     last_served;
  logic              dir_rd;
  logic [31:0]       lba;
  logic [5:0]        last;
  logic [13:0]       ofs;

  logic [SUBDRV-1:0] pending;
  logic              win_valid;
  logic [DW-1:0]     win;
  logic              win_rd;
  logic              at_end;
  int                idx;

  genvar gi;
  generate
    for (gi = 0; gi < SUBDRV; gi++) begin : g_pend
      assign pending[gi] = sd_rd[gi] | sd_wr[gi];
    end
  endgenerate

  // Round-robin: walk from the farthest candidate to the nearest so the
  // subdrive right after the last-served one overrides everything else.
  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    idx       = 0;
    for (int k = SUBDRV; k >= 1; k--) begin
      idx = (int'(last_served) + k) % SUBDRV;
      if (pending[idx]) begin
        win_valid = 1'b1;
        win       = DW'(idx);
      end
    end
  end

  assign win_rd       = sd_rd[win];
  assign at_end       = (ofs == {last, 8'hFF});
  assign sd_buff_addr = ofs;
  assign mem_addr     = AW'({lba, 8'h00}) + AW'(ofs);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      drv          <= '0;
      last_served  <= DW'(NS);
      dir_rd       <= 1'b0;
      lba          <= '0;
      last         <= '0;
      ofs          <= '0;
      sd_ack       <= '0;
      sd_buff_wr   <= 1'b0;
      sd_buff_dout <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_dout     <= '0;
    end else begin
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      sd_buff_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            drv    <= win;
            dir_rd <= win_rd;
            state  <= START;
          end
        end
        START: begin
          lba         <= sd_lba[drv];
          last        <= sd_blk_cnt[drv];
          ofs         <= '0;
          sd_ack      <= '0;
          sd_ack[drv] <= 1'b1;
          state       <= dir_rd ? RD_REQ : WR_ADDR;
        end
        RD_REQ: begin
          mem_rd <= 1'b1;
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_ready) begin
            sd_buff_dout <= mem_din;
            sd_buff_wr   <= 1'b1;
            state        <= RD_PUT;
          end
        end
        RD_PUT: begin
          // Ack drops together with the move to DONE so it falls right after the last strobe.
          if (at_end) begin
            sd_ack <= '0;
            state  <= DONE;
          end else begin
            ofs   <= ofs + 14'd1;
            state <= RD_REQ;
          end
        end
        WR_ADDR: state <= WR_REQ;
        WR_REQ: begin
          mem_dout <= sd_buff_din[drv];
          mem_wr   <= 1'b1;
          state    <= WR_WAIT;
        end
        WR_WAIT: begin
          if (mem_ready) begin
            if (at_end) begin
              sd_ack <= '0;
              state  <= DONE;
            end else begin
              ofs   <= ofs + 14'd1;
              state <= WR_ADDR;
            end
          end
        end
        DONE: begin
          sd_ack      <= '0;
          last_served <= drv;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ieeedrv_sd_resp.sv
// Bench for ieeedrv_sd_resp: image memory and track buffer models, table and random
// transfers checked against address/data streams predicted from the transfer rules.
`timescale 1ns/1ps
module tb_ieeedrv_sd_resp;
  localparam int SUBDRV = 2;
  localparam int AW     = 24;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       sd_lba      [SUBDRV];
  logic [5:0]        sd_blk_cnt  [SUBDRV];
  logic [SUBDRV-1:0] sd_rd;
  logic [SUBDRV-1:0] sd_wr;
  logic [SUBDRV-1:0] sd_ack;
  logic [13:0]       sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din [SUBDRV];
  logic [AW-1:0]     mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              mem_ready;

  ieeedrv_sd_resp #(.SUBDRV(SUBDRV), .AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ready(mem_ready)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Reference contents of the image and of each subdrive's track buffer.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] buf_byte(input int d, input int o);
    return 8'(o) ^ 8'(o >> 8) ^ ((d == 1) ? 8'hC3 : 8'h00);
  endfunction
  function automatic logic [AW-1:0] img_addr(input logic [31:0] l, input int k);
    longint full;
    full = longint'(l) * 256 + longint'(k);
    return AW'(full % (longint'(1) << AW));
  endfunction

  // Track buffers: one-cycle read latency from sd_buff_addr.
  always @(posedge clk_sys) begin
    for (int i = 0; i < SUBDRV; i++) sd_buff_din[i] <= buf_byte(i, int'(sd_buff_addr));
  end

  // Image memory: mem_ready exactly lat cycles after each strobe.
  int         lat = 1;
  logic       inject = 1'b0;
  int         pend_cnt = 0;
  logic       pend_rd = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  always @(posedge clk_sys) begin
    if (mem_rd || mem_wr) begin
      pend_rd   <= mem_rd;
      pend_addr <= mem_addr;
      if (lat == 1) begin
        mem_ready <= 1'b1;
        if (mem_rd) mem_din <= mem_byte(mem_addr);
        pend_cnt  <= 0;
      end else begin
        mem_ready <= inject;
        pend_cnt  <= lat - 1;
      end
    end else if (pend_cnt == 1) begin
      mem_ready <= 1'b1;
      if (pend_rd) mem_din <= mem_byte(pend_addr);
      pend_cnt  <= 0;
    end else begin
      mem_ready <= inject;
      if (pend_cnt > 1) pend_cnt <= pend_cnt - 1;
    end
  end

  // Event capture on the falling edge.
  logic [AW-1:0]     rd_q [$];
  logic [AW-1:0]     wa_q [$];
  logic [7:0]        wd_q [$];
  logic [13:0]       ba_q [$];
  logic [7:0]        bd_q [$];
  logic [SUBDRV-1:0] bk_q [$];
  int ack_total = 0;
  int excl_bad  = 0;
  always @(negedge clk_sys) begin
    if (mem_rd) rd_q.push_back(mem_addr);
    if (mem_wr) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_dout);
    end
    if (sd_buff_wr) begin
      ba_q.push_back(sd_buff_addr);
      bd_q.push_back(sd_buff_dout);
      bk_q.push_back(sd_ack);
    end
    if (sd_ack != '0) ack_total <= ack_total + 1;
    if ((mem_rd && mem_wr) || ($countones(sd_ack) > 1)) excl_bad <= excl_bad + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Runs one transfer for drv and checks every byte moved against the model.
  task automatic serve(input int drv, input bit rd, input bit wr, input logic [31:0] lba,
                       input logic [5:0] cnt, input int L, input bit raise,
                       input bit exp_rd, input int exp_n);
    int s_rd, s_wa, s_ba, a0, w, errs, first;
    logic [SUBDRV-1:0] want;
    logic [AW-1:0] a;
    want = '0;
    want[drv] = 1'b1;
    lat = L;
    if (raise) begin
      cyc(2);
      sd_lba[drv] = lba; sd_blk_cnt[drv] = cnt; sd_rd[drv] = rd; sd_wr[drv] = wr;
    end
    s_rd = rd_q.size(); s_wa = wa_q.size(); s_ba = ba_q.size(); a0 = ack_total;
    if (raise) begin
      cyc(1); check("ack_early", 64'(sd_ack), 0);
      cyc(1); check("ack_lat", 64'(sd_ack), 64'(want));
      if (exp_rd) begin
        cyc(1); check("first_rd", 64'(mem_rd), 1);
      end
    end
    w = 0;
    while (sd_ack !== want && w < 20) begin cyc(1); w++; end
    check("ack_seen", 64'(sd_ack), 64'(want));
    sd_rd[drv] = 1'b0; sd_wr[drv] = 1'b0;
    sd_lba[drv] = $urandom; sd_blk_cnt[drv] = 6'($urandom);
    w = 0;
    while (sd_ack !== '0 && w < exp_n * (3 + L) + 40) begin cyc(1); w++; end
    check("ack_fall", 64'(sd_ack), 0);
    errs = 0; first = -1;
    if (exp_rd) begin
      check("buf_wr_cnt", 64'(ba_q.size() - s_ba), 64'(exp_n));
      check("mem_rd_cnt", 64'(rd_q.size() - s_rd), 64'(exp_n));
      check("mem_wr_none", 64'(wa_q.size() - s_wa), 0);
      if (ba_q.size() - s_ba >= exp_n && rd_q.size() - s_rd >= exp_n)
        for (int k = 0; k < exp_n; k++) begin
          a = img_addr(lba, k);
          if (rd_q[s_rd+k] !== a || ba_q[s_ba+k] !== 14'(k) ||
              bd_q[s_ba+k] !== mem_byte(a) || bk_q[s_ba+k] !== want) begin
            errs++; if (first < 0) first = k;
          end
        end
      check($sformatf("rd_stream@%0d", first), 64'(errs), 0);
    end else begin
      check("mem_wr_cnt", 64'(wa_q.size() - s_wa), 64'(exp_n));
      check("buf_wr_none", 64'(ba_q.size() - s_ba), 0);
      check("mem_rd_none", 64'(rd_q.size() - s_rd), 0);
      if (wa_q.size() - s_wa >= exp_n)
        for (int k = 0; k < exp_n; k++) begin
          if (wa_q[s_wa+k] !== img_addr(lba, k) || wd_q[s_wa+k] !== buf_byte(drv, k)) begin
            errs++; if (first < 0) first = k;
          end
        end
      check($sformatf("wr_stream@%0d", first), 64'(errs), 0);
    end
    check("ack_len", 64'(ack_total - a0), 64'(exp_n * (3 + L)));
    $display("xfer drv=%0d dir=%s lba=%08h cnt=%0d L=%0d bytes=%0d", drv,
             exp_rd ? "rd" : "wr", lba, cnt, L, exp_n);
  endtask

  typedef struct {
    int          drv;
    bit          rd;
    bit          wr;
    logic [31:0] lba;
    logic [5:0]  cnt;
    int          lat;
    bit          exp_rd;
    int          exp_n;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int w, s_ba, s_rd, a0, d, mode;
    logic [31:0] rl;
    logic [5:0]  rc;
    int          rlat;
    vecs[0] = '{drv: 1, rd: 1, wr: 1, lba: 32'h0000_0077, cnt: 6'd0,  lat: 2, exp_rd: 1, exp_n: 256};
    vecs[1] = '{drv: 0, rd: 1, wr: 0, lba: 32'h000F_FFFF, cnt: 6'd1,  lat: 1, exp_rd: 1, exp_n: 512};
    vecs[2] = '{drv: 1, rd: 0, wr: 1, lba: 32'h000F_FFFF, cnt: 6'd1,  lat: 2, exp_rd: 0, exp_n: 512};
    vecs[3] = '{drv: 0, rd: 0, wr: 1, lba: 32'h0000_1000, cnt: 6'd28, lat: 3, exp_rd: 0, exp_n: 7424};
    vecs[4] = '{drv: 1, rd: 1, wr: 0, lba: 32'h0000_0123, cnt: 6'd2,  lat: 1, exp_rd: 1, exp_n: 768};

    sd_rd = '0; sd_wr = '0;
    for (int i = 0; i < SUBDRV; i++) begin sd_lba[i] = '0; sd_blk_cnt[i] = '0; end
    #2 reset = 1'b1;
    cyc(2);
    check("rst_ack", 64'(sd_ack), 0);
    check("rst_buf_wr", 64'(sd_buff_wr), 0);
    check("rst_mem_rd", 64'(mem_rd), 0);
    check("rst_mem_wr", 64'(mem_wr), 0);
    check("rst_buf_addr", 64'(sd_buff_addr), 0);
    check("rst_buf_dout", 64'(sd_buff_dout), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    check("rst_mem_dout", 64'(mem_dout), 0);
    reset = 1'b0;
    cyc(2);

    // Simultaneous requests after reset: drive 0 first, then 1, twice over.
    for (int r = 0; r < 2; r++) begin
      sd_lba[0] = 32'h200 + 32'(r); sd_blk_cnt[0] = 6'd0; sd_rd[0] = 1'b1;
      sd_lba[1] = 32'h300 + 32'(r); sd_blk_cnt[1] = 6'd0; sd_wr[1] = 1'b1;
      serve(0, 1, 0, 32'h200 + 32'(r), 6'd0, 1, 0, 1, 256);
      serve(1, 0, 1, 32'h300 + 32'(r), 6'd0, 1, 0, 0, 256);
    end

    // Single-sector read, last-served becomes 0.
    serve(0, 1, 0, 32'h5, 6'd0, 1, 1, 1, 256);
    // Pair again: drive 1 now comes first.
    cyc(2);
    sd_lba[0] = 32'h400; sd_blk_cnt[0] = 6'd0; sd_wr[0] = 1'b1;
    sd_lba[1] = 32'h500; sd_blk_cnt[1] = 6'd0; sd_rd[1] = 1'b1;
    serve(1, 1, 0, 32'h500, 6'd0, 2, 0, 1, 256);
    serve(0, 0, 1, 32'h400, 6'd0, 2, 0, 0, 256);

    for (int v = 0; v < 5; v++)
      serve(vecs[v].drv, vecs[v].rd, vecs[v].wr, vecs[v].lba, vecs[v].cnt,
            vecs[v].lat, 1, vecs[v].exp_rd, vecs[v].exp_n);

    for (int r = 0; r < 5; r++) begin
      d    = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 2));
      rl   = $urandom;
      rc   = 6'($urandom_range(0, 1));
      rlat = int'($urandom_range(1, 3));
      serve(d, mode != 1, mode != 0, rl, rc, rlat, 1, mode != 1, (int'(rc) + 1) * 256);
    end

    // Reset while byte 100 of a read is in flight.
    lat = 2;
    cyc(2);
    sd_lba[0] = 32'h42; sd_blk_cnt[0] = 6'd0; sd_rd[0] = 1'b1;
    s_ba = ba_q.size();
    w = 0;
    while (ba_q.size() - s_ba < 100 && w < 2000) begin cyc(1); w++; end
    w = 0;
    while (mem_rd !== 1'b1 && w < 10) begin cyc(1); w++; end
    check("mid_busy", {61'd0, sd_ack, mem_rd}, 64'b011);
    #2 reset = 1'b1;
    sd_rd = '0;
    #1;
    check("mid_rst_ack", 64'(sd_ack), 0);
    check("mid_rst_mem_rd", 64'(mem_rd), 0);
    check("mid_rst_buf_wr", 64'(sd_buff_wr), 0);
    cyc(2);
    check("mid_rst_buf_addr", 64'(sd_buff_addr), 0);
    check("mid_rst_mem_addr", 64'(mem_addr), 0);
    reset = 1'b0;
    s_ba = ba_q.size(); s_rd = rd_q.size(); a0 = ack_total;
    inject = 1'b1; cyc(1); inject = 1'b0;
    cyc(20);
    check("stale_buf_wr", 64'(ba_q.size() - s_ba), 0);
    check("stale_mem_rd", 64'(rd_q.size() - s_rd), 0);
    check("stale_ack", 64'(ack_total - a0), 0);
    serve(0, 1, 0, 32'h42, 6'd0, 1, 1, 1, 256);

    check("exclusive", 64'(excl_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
